// File: rtl/fm_period_demod.sv
// Period-counting FM demodulator: times rising edges of fin, averages 2^AVG_LOG2 periods
// and reports centre minus window sum. Define FM_PERIOD_DEMOD_SYNC_EN to add a 2-flop input synchroniser.
`timescale 1ns/1ps
module fm_period_demod #(
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 2,
    parameter int OUT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      fin,
    input  logic [CNT_W+AVG_LOG2-1:0] center,
    output logic signed [OUT_W-1:0]   fm,
    output logic                      fm_valid,
    output logic [CNT_W-1:0]          period,
    output logic                      locked,
    output logic                      timeout
);

    localparam int D      = 1 << AVG_LOG2;
    localparam int SUM_W  = CNT_W + AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_TRACK = 2'd3;

    function automatic logic [SUM_W-1:0] window_update(
        input logic [SUM_W-1:0] sum_in,
        input logic [CNT_W-1:0] add_in,
        input logic [CNT_W-1:0] drop_in
    );
        return sum_in + SUM_W'(add_in) - SUM_W'(drop_in);
    endfunction

    function automatic logic signed [OUT_W-1:0] deviation(
        input logic [SUM_W-1:0] ctr,
        input logic [SUM_W-1:0] sum_in
    );
        logic signed [SUM_W:0] diff;
        diff = $signed({1'b0, ctr}) - $signed({1'b0, sum_in});
        return OUT_W'(diff);
    endfunction

    logic             fin_i;
    logic             fin_d1;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [FILL_W-1:0] fill;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] win_buf [D];
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] per_p0;
    logic [CNT_W-1:0] old_p0;
    logic             vld_p0;
    logic             emit_p0;

    logic edge_det;
    logic active;
    logic sat;
    logic capture;
    logic emit;
    logic wclr;

`ifdef FM_PERIOD_DEMOD_SYNC_EN
    logic fin_s1;
    logic fin_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            fin_s1 <= 1'b0;
            fin_s2 <= 1'b0;
        end else begin
            fin_s1 <= fin;
            fin_s2 <= fin_s1;
        end
    end

    assign fin_i = fin_s2;
`else
    assign fin_i = fin;
`endif

    assign edge_det = fin_i & ~fin_d1;
    assign active   = (state == S_FILL) || (state == S_TRACK);
    assign sat      = run & active & (cnt == CNT_MAX);
    assign capture  = run & active & ~sat & edge_det;
    assign emit     = capture & ((state == S_TRACK) || (fill == FILL_W'(D - 1)));
    // Window is emptied whenever tracking is abandoned, so every re-arm starts from zero.
    assign wclr     = reset | ~run | sat | ~active;

    always_comb begin
        state_next = state;
        if (!run) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_next = S_ARM;
                S_ARM:   if (edge_det) state_next = S_FILL;
                S_FILL, S_TRACK: begin
                    if (sat)       state_next = edge_det ? S_FILL : S_ARM;
                    else if (emit) state_next = S_TRACK;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Stage p0: edge capture, period counter and control
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            fin_d1   <= 1'b0;
            cnt      <= '0;
            fill     <= '0;
            ptr      <= '0;
            vld_p0   <= 1'b0;
            emit_p0  <= 1'b0;
            fm_valid <= 1'b0;
            locked   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_next;
            fin_d1  <= fin_i;
            vld_p0  <= capture;
            emit_p0 <= emit;
            timeout <= sat;

            if (!run || state == S_IDLE)
                cnt <= '0;
            else if (edge_det)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);

            if (state != S_FILL || sat || !run)
                fill <= '0;
            else if (capture)
                fill <= fill + FILL_W'(1);

            if (wclr)
                ptr <= '0;
            else if (capture)
                ptr <= (ptr == PTR_W'(D - 1)) ? '0 : ptr + PTR_W'(1);

            fm_valid <= run & ~sat & emit_p0;
            // Held only from the first strobe until tracking is left, so it lines up with fm_valid.
            locked   <= (state_next == S_TRACK) & (locked | emit_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (wclr) begin
            for (int i = 0; i < D; i++)
                win_buf[i] <= '0;
        end else if (capture) begin
            win_buf[ptr] <= cnt;
        end
        if (capture) begin
            per_p0 <= cnt;
            old_p0 <= win_buf[ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            period <= '0;
        else if (capture)
            period <= cnt;
    end

    // Stage p1: window sum and deviation output
    always_ff @(posedge clk) begin
        if (wclr)
            sum <= '0;
        else if (vld_p0)
            sum <= window_update(sum, per_p0, old_p0);
    end

    always_ff @(posedge clk) begin
        if (reset || sat)
            fm <= '0;
        else if (run && emit_p0)
            fm <= deviation(center, window_update(sum, per_p0, old_p0));
    end

endmodule

// File: tb/tb_fm_period_demod.sv
// Bench for fm_period_demod: a cycle model pushes expected strobes into a scoreboard queue,
// plus a CNT_W=8 instance for the saturation scenario.
`timescale 1ns/1ps
module tb_fm_period_demod;

    localparam int D = 4;
`ifdef FM_PERIOD_DEMOD_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic               fin;
    logic [17:0]        center;
    logic [9:0]         center8;
    logic signed [31:0] fm;
    logic signed [31:0] fm8;
    logic               fm_valid;
    logic               fm_valid8;
    logic [15:0]        period;
    logic [7:0]         period8;
    logic               locked;
    logic               locked8;
    logic               timeout;
    logic               timeout8;

    fm_period_demod dut (
        .clk(clk), .reset(reset), .run(run), .fin(fin), .center(center),
        .fm(fm), .fm_valid(fm_valid), .period(period), .locked(locked), .timeout(timeout)
    );

    fm_period_demod #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .run(run), .fin(fin), .center(center8),
        .fm(fm8), .fm_valid(fm_valid8), .period(period8), .locked(locked8), .timeout(timeout8)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int fm;
        int per;
    } exp_t;

    exp_t exp_q[$];
    int   win[$];
    int   m_state = 0;
    int   m_last  = 0;
    logic m_prev  = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_strobe = 0;
    int   n_strobe8 = 0;

    task automatic model_step();
        logic edge_seen;
        int   p;
        int   s;
        edge_seen = fin && !m_prev;
        m_prev = fin;
        if (reset) begin
            m_state = 0;
            m_prev  = 1'b0;
            win.delete();
            exp_q.delete();
        end else if (!run) begin
            m_state = 0;
            win.delete();
            while (exp_q.size() > 0 && exp_q[$].cyc >= cyc)
                void'(exp_q.pop_back());
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (edge_seen) begin
                    m_state = 2;
                    m_last  = cyc;
                    win.delete();
                end
                default: if (edge_seen) begin
                    p = cyc - m_last;
                    m_last = cyc;
                    win.push_back(p);
                    if (win.size() > D)
                        void'(win.pop_front());
                    if (win.size() == D) begin
                        s = 0;
                        foreach (win[i]) s += win[i];
                        exp_q.push_back('{cyc + 1 + SYNC_D, int'(center) - s, p});
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic drive_periods(input int n, input int p);
        for (int i = 0; i < n; i++) begin
            fin = 1'b1;
            for (int j = 0; j < p / 2; j++) tick();
            fin = 1'b0;
            for (int j = p / 2; j < p; j++) tick();
        end
    endtask

    always @(negedge clk) begin
        if (fm_valid8 === 1'b1) n_strobe8++;
        if (fm_valid === 1'b1) begin
            n_strobe++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: fm_valid at cycle %0d fm %0d, expected none", cyc, fm);
            end else begin
                exp_t ex;
                ex = exp_q.pop_front();
                if (cyc != ex.cyc || fm !== ex.fm || 32'(period) !== ex.per || locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL strobe: got cycle %0d fm %0d period %0d locked %b, want cycle %0d fm %0d period %0d locked 1",
                             cyc, fm, period, locked, ex.cyc, ex.fm, ex.per);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        fin   = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({fm, fm_valid, period, locked, timeout} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got fm %0d valid %b period %0d locked %b timeout %b, want all 0",
                     fm, fm_valid, period, locked, timeout);
        end
        n_cmp++;
        if ({fm8, locked8, timeout8} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs8: got fm %0d locked %b timeout %b, want all 0", fm8, locked8, timeout8);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_steady();
        int s0;
        run = 1'b1;
        repeat (3) tick();
        drive_periods(1, 10);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL steady_locked_after_arm: got %b, want 0", locked);
        end
        s0 = n_strobe;
        drive_periods(4, 10);
        n_cmp++;
        if (n_strobe - s0 != 1) begin
            n_fail++;
            $display("FAIL steady_first_strobe: got %0d strobes, want 1", n_strobe - s0);
        end
        drive_periods(2, 10);
        n_cmp++;
        if (n_strobe - s0 != 3) begin
            n_fail++;
            $display("FAIL steady_strobe_count: got %0d, want 3", n_strobe - s0);
        end
        n_cmp++;
        if (fm !== 32'sd0 || period !== 16'd10 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL steady_outputs: got fm %0d period %0d locked %b, want 0 10 1", fm, period, locked);
        end
    endtask

    task automatic test_step();
        int s0;
        s0 = n_strobe;
        drive_periods(6, 8);
        n_cmp++;
        if (n_strobe - s0 != 6) begin
            n_fail++;
            $display("FAIL step_strobe_count: got %0d, want 6", n_strobe - s0);
        end
        n_cmp++;
        if (fm !== 32'sd8 || period !== 16'd8) begin
            n_fail++;
            $display("FAIL step_final: got fm %0d period %0d, want 8 8", fm, period);
        end
    endtask

    task automatic test_timeout();
        int   first;
        int   pulses;
        int   want;
        int   s8;
        logic bad_valid;
        logic locked_at;
        logic signed [31:0] fm_at;
        first = -1;
        pulses = 0;
        bad_valid = 1'b0;
        locked_at = 1'b1;
        fm_at = 32'sd1;
        want = m_last + SYNC_D + 255;
        n_cmp++;
        if (locked8 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pre_locked8: got %b, want 1", locked8);
        end
        fin = 1'b0;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (timeout8 === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = cyc;
                    locked_at = locked8;
                    fm_at = fm8;
                end
            end
            if (fm_valid8 === 1'b1) bad_valid = 1'b1;
        end
        n_cmp++;
        if (pulses != 1 || first != want) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %0d pulses first at %0d, want 1 at %0d", pulses, first, want);
        end
        n_cmp++;
        if (locked_at !== 1'b0 || fm_at !== 32'sd0 || bad_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: got locked %b fm %0d stray_valid %b, want 0 0 0", locked_at, fm_at, bad_valid);
        end
        n_cmp++;
        if (locked !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_wide_counter: got locked %b timeout %b, want 1 0", locked, timeout);
        end
        s8 = n_strobe8;
        drive_periods(4, 10);
        n_cmp++;
        if (n_strobe8 - s8 != 0) begin
            n_fail++;
            $display("FAIL timeout_refill_early: got %0d strobes, want 0", n_strobe8 - s8);
        end
        drive_periods(1, 10);
        n_cmp++;
        if (n_strobe8 - s8 != 1 || fm8 !== 32'sd0 || period8 !== 8'd10 || locked8 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_recover: got %0d strobes fm %0d period %0d locked %b, want 1 0 10 1",
                     n_strobe8 - s8, fm8, period8, locked8);
        end
    endtask

    task automatic test_run_drop();
        int s0;
        s0 = n_strobe;
        run = 1'b0;
        repeat (5) tick();
        run = 1'b1;
        repeat (3) tick();
        drive_periods(3, 10);
        run = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (locked !== 1'b0 || fm_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_low_state: got locked %b valid %b, want 0 0", locked, fm_valid);
        end
        run = 1'b1;
        repeat (3) tick();
        drive_periods(4, 10);
        n_cmp++;
        if (n_strobe - s0 != 0) begin
            n_fail++;
            $display("FAIL run_drop_early_strobe: got %0d, want 0", n_strobe - s0);
        end
        drive_periods(1, 10);
        n_cmp++;
        if (n_strobe - s0 != 1 || fm !== 32'sd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL run_drop_recover: got %0d strobes fm %0d locked %b, want 1 0 1", n_strobe - s0, fm, locked);
        end
    endtask

    task automatic test_reset_in_track();
        int s0;
        s0 = n_strobe;
        fin   = 1'b1;
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({fm, fm_valid, period, locked, timeout} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_in_track: got fm %0d valid %b period %0d locked %b timeout %b, want all 0",
                     fm, fm_valid, period, locked, timeout);
        end
        reset = 1'b0;
        run   = 1'b0;
        fin   = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (n_strobe != s0 || locked !== 1'b0 || fm !== 32'sd0) begin
            n_fail++;
            $display("FAIL reset_in_track_after: got %0d strobes locked %b fm %0d, want 0 0 0", n_strobe - s0, locked, fm);
        end
    endtask

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        fin     = 1'b0;
        center  = 18'd40;
        center8 = 10'd40;
        test_reset();
        test_steady();
        test_step();
        test_timeout();
        test_run_drop();
        test_reset_in_track();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL strobe_missing: got %0d outstanding, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
